// File: rtl/smoldvi_timing_if.sv
// Video timing bus: run enable in, syncs / data enable / pixel fetch requests out.
interface smoldvi_timing_if #(
  parameter int CW = 12
);
  logic          en;
  logic          hsync;
  logic          vsync;
  logic          den;
  logic          fetch_valid;
  logic [CW-1:0] fetch_x;
  logic [CW-1:0] fetch_y;
  logic          line_start;
  logic          frame_start;

  // Consumer side: drives the run enable, observes timing.
  modport master (
    output en,
    input  hsync, vsync, den, fetch_valid, fetch_x, fetch_y, line_start, frame_start
  );

  // Timing generator side.
  modport slave (
    input  en,
    output hsync, vsync, den, fetch_valid, fetch_x, fetch_y, line_start, frame_start
  );
endinterface

// File: rtl/smoldvi_timing.sv
// DVI video timing controller: phase FSMs with down-counters for sync/den,
// a primary (h,v) position and a lead (h,v) position FETCH_LEAD pixels ahead
// that issues pixel fetch requests. All outputs are registered.
module smoldvi_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int FETCH_LEAD = 2,
  parameter int CW         = 12
) (
  input  logic            clk_pix,
  input  logic            rst_n_pix,
  smoldvi_timing_if.slave vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [1:0] ST_ACT = 2'd0;
  localparam logic [1:0] ST_FP  = 2'd1;
  localparam logic [1:0] ST_SY  = 2'd2;
  localparam logic [1:0] ST_BP  = 2'd3;

  localparam logic [CW-1:0] ZERO       = {CW{1'b0}};
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] H_ACT_LEN  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_FP_LEN   = CW'(H_FRONT);
  localparam logic [CW-1:0] H_SY_LEN   = CW'(H_SYNC);
  localparam logic [CW-1:0] H_BP_LEN   = CW'(H_BACK);
  localparam logic [CW-1:0] V_ACT_LEN  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_FP_LEN   = CW'(V_FRONT);
  localparam logic [CW-1:0] V_SY_LEN   = CW'(V_SYNC);
  localparam logic [CW-1:0] V_BP_LEN   = CW'(V_BACK);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  // FETCH_LEAD < H_TOTAL, so the lead idle position never wraps the line.
  localparam logic [CW-1:0] LEAD_IDLE_H = CW'(FETCH_LEAD);

  logic [1:0]    h_state_r, h_state_s, v_state_r, v_state_s;
  logic [CW-1:0] h_cnt_r, h_cnt_s, v_cnt_r, v_cnt_s;
  logic [CW-1:0] h_pos_r, h_pos_s, v_pos_r, v_pos_s;
  logic [CW-1:0] lead_h_r, lead_h_s, lead_v_r, lead_v_s;
  logic          line_end_s;
  logic          den_s, lead_act_s;

  // Phase FSMs: horizontal steps every pixel, vertical only at the BP->ACT line boundary.
  always_comb begin
    h_state_s  = h_state_r;
    h_cnt_s    = h_cnt_r - ONE;
    v_state_s  = v_state_r;
    v_cnt_s    = v_cnt_r;
    line_end_s = 1'b0;
    if (h_cnt_r == ONE) begin
      case (h_state_r)
        ST_ACT:  begin h_state_s = ST_FP;  h_cnt_s = H_FP_LEN;  end
        ST_FP:   begin h_state_s = ST_SY;  h_cnt_s = H_SY_LEN;  end
        ST_SY:   begin h_state_s = ST_BP;  h_cnt_s = H_BP_LEN;  end
        ST_BP:   begin h_state_s = ST_ACT; h_cnt_s = H_ACT_LEN; line_end_s = 1'b1; end
        default: begin h_state_s = ST_ACT; h_cnt_s = H_ACT_LEN; end
      endcase
    end else begin
      h_state_s = h_state_r;
    end
    if (line_end_s) begin
      if (v_cnt_r == ONE) begin
        case (v_state_r)
          ST_ACT:  begin v_state_s = ST_FP;  v_cnt_s = V_FP_LEN;  end
          ST_FP:   begin v_state_s = ST_SY;  v_cnt_s = V_SY_LEN;  end
          ST_SY:   begin v_state_s = ST_BP;  v_cnt_s = V_BP_LEN;  end
          ST_BP:   begin v_state_s = ST_ACT; v_cnt_s = V_ACT_LEN; end
          default: begin v_state_s = ST_ACT; v_cnt_s = V_ACT_LEN; end
        endcase
      end else begin
        v_cnt_s = v_cnt_r - ONE;
      end
    end else begin
      v_cnt_s = v_cnt_r;
    end
  end

  // Primary and lead raster positions; both wrap at line and frame ends identically.
  always_comb begin
    h_pos_s  = h_pos_r + ONE;
    v_pos_s  = v_pos_r;
    lead_h_s = lead_h_r + ONE;
    lead_v_s = lead_v_r;
    if (h_pos_r == H_LAST) begin
      h_pos_s = ZERO;
      if (v_pos_r == V_LAST) begin
        v_pos_s = ZERO;
      end else begin
        v_pos_s = v_pos_r + ONE;
      end
    end else begin
      h_pos_s = h_pos_r + ONE;
    end
    if (lead_h_r == H_LAST) begin
      lead_h_s = ZERO;
      if (lead_v_r == V_LAST) begin
        lead_v_s = ZERO;
      end else begin
        lead_v_s = lead_v_r + ONE;
      end
    end else begin
      lead_h_s = lead_h_r + ONE;
    end
  end

  // Decode of the current positions feeding the output registers.
  always_comb begin
    den_s      = (h_state_r == ST_ACT) && (v_state_r == ST_ACT);
    lead_act_s = (lead_h_r < H_ACT_LEN) && (lead_v_r < V_ACT_LEN);
  end

  // Timing state: parked at the idle position in reset or while disabled.
  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      h_state_r <= ST_ACT;     h_cnt_r  <= H_ACT_LEN;
      v_state_r <= ST_BP;      v_cnt_r  <= ONE;
      h_pos_r   <= ZERO;       v_pos_r  <= V_LAST;
      lead_h_r  <= LEAD_IDLE_H; lead_v_r <= V_LAST;
    end else if (!vid.en) begin
      h_state_r <= ST_ACT;     h_cnt_r  <= H_ACT_LEN;
      v_state_r <= ST_BP;      v_cnt_r  <= ONE;
      h_pos_r   <= ZERO;       v_pos_r  <= V_LAST;
      lead_h_r  <= LEAD_IDLE_H; lead_v_r <= V_LAST;
    end else begin
      h_state_r <= h_state_s;  h_cnt_r  <= h_cnt_s;
      v_state_r <= v_state_s;  v_cnt_r  <= v_cnt_s;
      h_pos_r   <= h_pos_s;    v_pos_r  <= v_pos_s;
      lead_h_r  <= lead_h_s;   lead_v_r <= lead_v_s;
    end
  end

  // Output registers: one cycle behind the position; idle values while disabled.
  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      vid.hsync       <= ~H_SYNC_POL;
      vid.vsync       <= ~V_SYNC_POL;
      vid.den         <= 1'b0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.fetch_valid <= 1'b0;
      vid.fetch_x     <= ZERO;
      vid.fetch_y     <= ZERO;
    end else if (!vid.en) begin
      vid.hsync       <= ~H_SYNC_POL;
      vid.vsync       <= ~V_SYNC_POL;
      vid.den         <= 1'b0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.fetch_valid <= 1'b0;
      vid.fetch_x     <= ZERO;
      vid.fetch_y     <= ZERO;
    end else begin
      vid.hsync       <= (h_state_r == ST_SY) ? H_SYNC_POL : ~H_SYNC_POL;
      vid.vsync       <= (v_state_r == ST_SY) ? V_SYNC_POL : ~V_SYNC_POL;
      vid.den         <= den_s;
      vid.line_start  <= den_s && (h_pos_r == ZERO);
      vid.frame_start <= den_s && (h_pos_r == ZERO) && (v_pos_r == ZERO);
      vid.fetch_valid <= lead_act_s;
      if (lead_act_s) begin
        vid.fetch_x <= lead_h_r;
        vid.fetch_y <= lead_v_r;
      end else begin
        vid.fetch_x <= vid.fetch_x;
        vid.fetch_y <= vid.fetch_y;
      end
    end
  end
endmodule

// File: tb/tb_smoldvi_timing.sv
// Self-checking bench for smoldvi_timing: a tiny raster checked against a
// linear-index reference model, plus a 640x480 instance with maximum fetch lead.
module tb_smoldvi_timing;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int LEAD = 2, CW = 12;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int TOT = HT * VT;
  localparam int IDLE = (VT - 1) * HT;
  localparam int BIG_LEAD = 159, BIG_HT = 800, BIG_HA = 640;
  localparam logic [29:0] RST_VEC = {6'b110000, 24'd0};

  logic clk_pix = 1'b0;
  logic rst_n_pix = 1'b0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk_pix = ~clk_pix;

  smoldvi_timing_if #(.CW(CW)) bus ();
  smoldvi_timing_if #(.CW(CW)) bus_big ();

  smoldvi_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .FETCH_LEAD(LEAD), .CW(CW)
  ) dut (.clk_pix(clk_pix), .rst_n_pix(rst_n_pix), .vid(bus.slave));

  smoldvi_timing #(.FETCH_LEAD(BIG_LEAD), .CW(CW))
    dut_big (.clk_pix(clk_pix), .rst_n_pix(rst_n_pix), .vid(bus_big.slave));

  // Reference model: position as one linear index 0..TOT-1.
  int p;
  int m_dx, m_dy;
  logic m_hs, m_vs, m_den, m_ls, m_fs, m_fv;
  logic [CW-1:0] m_fx, m_fy;

  function automatic bit is_act(int idx);
    return ((idx % HT) < HA) && ((idx / HT) < VA);
  endfunction
  function automatic bit in_hsync(int idx);
    return ((idx % HT) >= HA + HF) && ((idx % HT) < HA + HF + HS);
  endfunction
  function automatic bit in_vsync(int idx);
    return ((idx / HT) >= VA + VF) && ((idx / HT) < VA + VF + VS);
  endfunction

  always @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix || !bus.en) begin
      m_hs <= 1'b1; m_vs <= 1'b1; m_den <= 1'b0; m_ls <= 1'b0; m_fs <= 1'b0;
      m_fv <= 1'b0; m_fx <= '0; m_fy <= '0; m_dx <= -1; m_dy <= -1;
      p <= IDLE;
    end else begin
      m_hs  <= !in_hsync(p);
      m_vs  <= !in_vsync(p);
      m_den <= is_act(p);
      m_ls  <= is_act(p) && (p % HT == 0);
      m_fs  <= (p == 0);
      m_fv  <= is_act((p + LEAD) % TOT);
      if (is_act((p + LEAD) % TOT)) begin
        m_fx <= CW'(((p + LEAD) % TOT) % HT);
        m_fy <= CW'(((p + LEAD) % TOT) / HT);
      end
      m_dx <= p % HT;
      m_dy <= p / HT;
      p <= (p + 1) % TOT;
    end
  end

  function automatic logic [29:0] obs_vec();
    return {bus.hsync, bus.vsync, bus.den, bus.line_start, bus.frame_start,
            bus.fetch_valid, bus.fetch_x, bus.fetch_y};
  endfunction
  function automatic logic [29:0] model_vec();
    return {m_hs, m_vs, m_den, m_ls, m_fs, m_fv, m_fx, m_fy};
  endfunction

  task automatic test_reset();
    bus.en = 1'b0; bus_big.en = 1'b0; rst_n_pix = 1'b0;
    repeat (3) @(negedge clk_pix);
    n_checks++; if (bus.hsync !== 1'b1) $display("FAIL reset_hsync: got %b expected 1", bus.hsync); else n_pass++;
    n_checks++; if (bus.vsync !== 1'b1) $display("FAIL reset_vsync: got %b expected 1", bus.vsync); else n_pass++;
    n_checks++; if (bus.den !== 1'b0) $display("FAIL reset_den: got %b expected 0", bus.den); else n_pass++;
    n_checks++; if ({bus.line_start, bus.frame_start, bus.fetch_valid} !== 3'b000)
      $display("FAIL reset_pulses: got %b expected 000", {bus.line_start, bus.frame_start, bus.fetch_valid}); else n_pass++;
    n_checks++; if ({bus.fetch_x, bus.fetch_y} !== 24'd0)
      $display("FAIL reset_fetch_xy: got %h expected 0", {bus.fetch_x, bus.fetch_y}); else n_pass++;
    rst_n_pix = 1'b1;
    repeat (4) @(negedge clk_pix);
    n_checks++; if (obs_vec() !== RST_VEC) $display("FAIL idle_en_low: got %h expected %h", obs_vec(), RST_VEC); else n_pass++;
  endtask

  task automatic test_startup();
    int first_den;
    logic ls, fs;
    logic [24:0] f7;
    first_den = 0; ls = 1'b0; fs = 1'b0; f7 = '0;
    bus.en = 1'b1;
    for (int k = 1; k <= 20 && first_den == 0; k++) begin
      @(negedge clk_pix);
      if (k == HT - 1) f7 = {bus.fetch_valid, bus.fetch_x, bus.fetch_y};
      if (bus.den === 1'b1) begin first_den = k; ls = bus.line_start; fs = bus.frame_start; end
    end
    n_checks++; if (first_den != HT + 1) $display("FAIL startup_latency: got %0d expected %0d", first_den, HT + 1); else n_pass++;
    n_checks++; if ({ls, fs} !== 2'b11) $display("FAIL startup_pulses: got %b expected 11", {ls, fs}); else n_pass++;
    n_checks++; if (f7 !== {1'b1, 24'd0}) $display("FAIL startup_fetch: got %h expected %h", f7, {1'b1, 24'd0}); else n_pass++;
  endtask

  task automatic test_frames();
    int dens, fs_last, hrun, vrun;
    bit ph, pv, hseen, vseen;
    dens = 0; fs_last = -1; hrun = 0; vrun = 0; hseen = 0; vseen = 0;
    ph = bus.hsync; pv = bus.vsync;
    for (int c = 0; c < 3 * TOT; c++) begin
      @(negedge clk_pix);
      n_checks++; if (obs_vec() !== model_vec()) $display("FAIL frames_model c=%0d: got %h expected %h", c, obs_vec(), model_vec()); else n_pass++;
      if (bus.den === 1'b1) dens++;
      if (bus.frame_start === 1'b1) begin
        if (fs_last >= 0) begin
          n_checks++; if (c - fs_last != TOT) $display("FAIL frame_period: got %0d expected %0d", c - fs_last, TOT); else n_pass++;
        end
        fs_last = c;
      end
      if (bus.hsync === 1'b0) begin
        if (ph) begin hrun = 0; hseen = 1; end
        hrun++;
      end else if (!ph && hseen) begin
        n_checks++; if (hrun != HS) $display("FAIL hsync_width: got %0d expected %0d", hrun, HS); else n_pass++;
      end
      ph = bus.hsync;
      if (bus.vsync === 1'b0) begin
        if (pv) begin
          vrun = 0; vseen = 1;
          n_checks++; if (m_dx != 0) $display("FAIL vsync_align: got h=%0d expected 0", m_dx); else n_pass++;
        end
        vrun++;
      end else if (!pv && vseen) begin
        n_checks++; if (vrun != VS * HT) $display("FAIL vsync_width: got %0d expected %0d", vrun, VS * HT); else n_pass++;
      end
      pv = bus.vsync;
    end
    n_checks++; if (dens != 3 * HA * VA) $display("FAIL den_count: got %0d expected %0d", dens, 3 * HA * VA); else n_pass++;
  endtask

  task automatic test_lead();
    logic [24:0] hist[$];
    logic [24:0] d;
    int frames;
    frames = 0;
    for (int c = 0; c < 5 * TOT; c++) begin
      @(negedge clk_pix);
      if (bus.frame_start === 1'b1) frames++;
      hist.push_back({bus.fetch_valid, bus.fetch_x, bus.fetch_y});
      if (hist.size() > LEAD) begin
        d = hist.pop_front();
        n_checks++;
        if (bus.den === 1'b1) begin
          if (d !== {1'b1, CW'(m_dx), CW'(m_dy)}) $display("FAIL lead_match c=%0d: got %h expected %h", c, d, {1'b1, CW'(m_dx), CW'(m_dy)}); else n_pass++;
        end else begin
          if (d[24] !== 1'b0) $display("FAIL lead_blank c=%0d: got fetch_valid=%b expected 0", c, d[24]); else n_pass++;
        end
      end
    end
    n_checks++; if (frames != 5) $display("FAIL lead_frames: got %0d expected 5", frames); else n_pass++;
  endtask

  task automatic test_abort();
    bit found;
    int fs_at;
    found = 0; fs_at = 0;
    for (int c = 0; c < 2 * TOT && !found; c++) begin
      @(negedge clk_pix);
      if (bus.den === 1'b1 && m_dx == 2 && m_dy == 1) found = 1;
    end
    n_checks++; if (!found) $display("FAIL abort_reach: got timeout expected pixel (2,1)"); else n_pass++;
    bus.en = 1'b0;
    @(negedge clk_pix);
    n_checks++; if (obs_vec() !== RST_VEC) $display("FAIL abort_idle: got %h expected %h", obs_vec(), RST_VEC); else n_pass++;
    bus.en = 1'b1;
    for (int k = 1; k <= 30 && fs_at == 0; k++) begin
      @(negedge clk_pix);
      if (bus.frame_start === 1'b1) fs_at = k;
    end
    n_checks++; if (fs_at != HT + 1) $display("FAIL abort_restart: got %0d expected %0d", fs_at, HT + 1); else n_pass++;
  endtask

  task automatic test_async_reset();
    repeat (20) @(negedge clk_pix);
    @(posedge clk_pix);
    #2;
    rst_n_pix = 1'b0;
    #1;
    n_checks++; if (obs_vec() !== RST_VEC) $display("FAIL async_reset: got %h expected %h", obs_vec(), RST_VEC); else n_pass++;
    @(negedge clk_pix);
    rst_n_pix = 1'b1;
    for (int c = 0; c < 2 * TOT; c++) begin
      @(negedge clk_pix);
      n_checks++; if (obs_vec() !== model_vec()) $display("FAIL recover_model c=%0d: got %h expected %h", c, obs_vec(), model_vec()); else n_pass++;
    end
  endtask

  task automatic test_big();
    logic [24:0] hist[$];
    logic [24:0] d;
    int first, dens, dx, dy;
    first = -1; dens = 0; dx = 0; dy = 0;
    bus_big.en = 1'b1;
    for (int c = 1; c <= 5 * BIG_HT; c++) begin
      @(negedge clk_pix);
      hist.push_back({bus_big.fetch_valid, bus_big.fetch_x, bus_big.fetch_y});
      if (bus_big.den === 1'b1) begin
        if (first < 0) begin
          first = c;
          n_checks++; if (c != BIG_HT + 1) $display("FAIL big_first_den: got %0d expected %0d", c, BIG_HT + 1); else n_pass++;
          n_checks++; if (bus_big.frame_start !== 1'b1) $display("FAIL big_frame_start: got %b expected 1", bus_big.frame_start); else n_pass++;
        end
        dens++;
      end
      if (hist.size() > BIG_LEAD) begin
        d = hist.pop_front();
        n_checks++;
        if (bus_big.den === 1'b1) begin
          if (d !== {1'b1, CW'(dx), CW'(dy)}) $display("FAIL big_lead c=%0d: got %h expected %h", c, d, {1'b1, CW'(dx), CW'(dy)}); else n_pass++;
        end else begin
          if (d[24] !== 1'b0) $display("FAIL big_lead_blank c=%0d: got fetch_valid=%b expected 0", c, d[24]); else n_pass++;
        end
      end
      if (bus_big.den === 1'b1) begin
        dx++;
      end else if (dx != 0) begin
        n_checks++; if (dx != BIG_HA) $display("FAIL big_line_len: got %0d expected %0d", dx, BIG_HA); else n_pass++;
        dx = 0; dy++;
      end
    end
    n_checks++; if (dens != 4 * BIG_HA) $display("FAIL big_den_count: got %0d expected %0d", dens, 4 * BIG_HA); else n_pass++;
  endtask

  initial begin
    bus.en = 1'b0;
    bus_big.en = 1'b0;
    test_reset();
    test_startup();
    test_frames();
    test_lead();
    test_abort();
    test_async_reset();
    test_big();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
